// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter and sequencer sharing one i2c_master between NUM_REQ requesters.
// Define I2C_ARB_RETRY_EN to re-issue NACKed transactions up to MAX_RETRIES times.
module i2c_master_arbiter #(
  parameter int unsigned NUM_REQ             = 4,
  parameter int unsigned MAX_TRANSFER_LENGTH = 2,
  parameter int unsigned TIMEOUT_CYCLES      = 65535,
  parameter int unsigned MAX_RETRIES         = 3,
  localparam int unsigned LW = $clog2(MAX_TRANSFER_LENGTH + 1),
  localparam int unsigned DW = MAX_TRANSFER_LENGTH * 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*7-1:0]  req_address,
  input  logic [NUM_REQ*DW-1:0] req_write_data,
  input  logic [NUM_REQ*LW-1:0] req_write_length,
  input  logic [NUM_REQ*LW-1:0] req_read_length,
  output logic [NUM_REQ-1:0]    req_ack,
  output logic [NUM_REQ-1:0]    rsp_done,
  output logic [DW-1:0]         rsp_read_data,
  output logic                  rsp_no_response,
  output logic                  rsp_timeout,
  output logic [LW-1:0]         rsp_total_written,
  output logic [LW-1:0]         rsp_total_read,
  output logic                  arb_busy,
  output logic [6:0]            m_i2c_address,
  output logic [DW-1:0]         m_write_data,
  output logic [LW-1:0]         m_write_transfer_length,
  output logic [LW-1:0]         m_read_transfer_length,
  output logic                  m_start,
  input  logic [DW-1:0]         m_read_data,
  input  logic                  m_busy,
  input  logic                  m_complete,
  input  logic                  m_no_response,
  input  logic [LW-1:0]         m_total_written,
  input  logic [LW-1:0]         m_total_read
);

  localparam int unsigned GW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [LW-1:0]  MaxLen = LW'(MAX_TRANSFER_LENGTH);
  localparam logic [WDW-1:0] WdLast = WDW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone,
    StResp
  } state_e;

  state_e               state_q, state_d;
  logic [GW-1:0]        last_grant_q, last_grant_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
  logic [6:0]           m_addr_q, m_addr_d;
  logic [DW-1:0]        m_wdata_q, m_wdata_d;
  logic [LW-1:0]        m_wlen_q, m_wlen_d;
  logic [LW-1:0]        m_rlen_q, m_rlen_d;
  logic                 m_start_q, m_start_d;
  logic [WDW-1:0]       wd_q, wd_d;
  logic [DW-1:0]        rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_nr_q, rsp_nr_d;
  logic                 rsp_to_q, rsp_to_d;
  logic [LW-1:0]        rsp_tw_q, rsp_tw_d;
  logic [LW-1:0]        rsp_tr_q, rsp_tr_d;

`ifdef I2C_ARB_RETRY_EN
  localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [RW-1:0] RetryMax = RW'(MAX_RETRIES);
  logic [RW-1:0] retry_q, retry_d;
`endif

  // Round-robin pick: the lowest offset k from last_grant+1 wins, so scan k downward.
  logic [GW-1:0] pick;
  logic          pick_vld;
  always_comb begin
    logic [GW:0] idx;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = {1'b0, last_grant_q} + (GW+1)'(k);
      if (idx >= (GW+1)'(NUM_REQ)) begin
        idx = idx - (GW+1)'(NUM_REQ);
      end
      if (req_valid[idx[GW-1:0]]) begin
        pick     = idx[GW-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  logic [6:0]    sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [LW-1:0] sel_wlen;
  logic [LW-1:0] sel_rlen;
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wlen  = '0;
    sel_rlen  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == GW'(i)) begin
        sel_addr  = req_address[7*i +: 7];
        sel_wdata = req_write_data[DW*i +: DW];
        sel_wlen  = req_write_length[LW*i +: LW];
        sel_rlen  = req_read_length[LW*i +: LW];
      end
    end
    if (sel_wlen > MaxLen) sel_wlen = MaxLen;
    if (sel_rlen > MaxLen) sel_rlen = MaxLen;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    req_ack_d    = '0;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    m_wlen_d     = m_wlen_q;
    m_rlen_d     = m_rlen_q;
    m_start_d    = 1'b0;
    wd_d         = wd_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_nr_d     = rsp_nr_q;
    rsp_to_d     = rsp_to_q;
    rsp_tw_d     = rsp_tw_q;
    rsp_tr_d     = rsp_tr_q;
`ifdef I2C_ARB_RETRY_EN
    retry_d      = retry_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          grant_d      = pick;
          last_grant_d = pick;
          req_ack_d    = NUM_REQ'(1) << pick;
          m_addr_d     = sel_addr;
          m_wdata_d    = sel_wdata;
          m_wlen_d     = sel_wlen;
          m_rlen_d     = sel_rlen;
`ifdef I2C_ARB_RETRY_EN
          retry_d      = '0;
`endif
          if (sel_wlen == '0 && sel_rlen == '0) begin
            // Nothing to transfer: report an all-zero result without touching the bus.
            state_d     = StResp;
            rsp_rdata_d = '0;
            rsp_nr_d    = 1'b0;
            rsp_to_d    = 1'b0;
            rsp_tw_d    = '0;
            rsp_tr_d    = '0;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        m_start_d = 1'b1;
        wd_d      = '0;
        state_d   = StWaitBusy;
      end
      StWaitBusy, StWaitDone: begin
        wd_d = wd_q + 1'b1;
        if (m_complete) begin
          state_d = StResp;
`ifdef I2C_ARB_RETRY_EN
          if (m_no_response && (retry_q < RetryMax)) begin
            retry_d = retry_q + 1'b1;
            state_d = StIssue;
          end
`endif
          if (state_d == StResp) begin
            rsp_rdata_d = m_read_data;
            rsp_nr_d    = m_no_response;
            rsp_to_d    = 1'b0;
            rsp_tw_d    = m_total_written;
            rsp_tr_d    = m_total_read;
          end
        end else if (wd_q == WdLast) begin
          state_d     = StResp;
          rsp_rdata_d = '0;
          rsp_nr_d    = 1'b1;
          rsp_to_d    = 1'b1;
          rsp_tw_d    = '0;
          rsp_tr_d    = '0;
        end else if (state_q == StWaitBusy && m_busy) begin
          state_d = StWaitDone;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= GW'(NUM_REQ - 1);
      grant_q      <= '0;
      req_ack_q    <= '0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_wlen_q     <= '0;
      m_rlen_q     <= '0;
      m_start_q    <= 1'b0;
      wd_q         <= '0;
      rsp_rdata_q  <= '0;
      rsp_nr_q     <= 1'b0;
      rsp_to_q     <= 1'b0;
      rsp_tw_q     <= '0;
      rsp_tr_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      req_ack_q    <= req_ack_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_wlen_q     <= m_wlen_d;
      m_rlen_q     <= m_rlen_d;
      m_start_q    <= m_start_d;
      wd_q         <= wd_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_nr_q     <= rsp_nr_d;
      rsp_to_q     <= rsp_to_d;
      rsp_tw_q     <= rsp_tw_d;
      rsp_tr_q     <= rsp_tr_d;
    end
  end

`ifdef I2C_ARB_RETRY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  assign req_ack                 = req_ack_q;
  assign rsp_done                = (state_q == StResp) ? (NUM_REQ'(1) << grant_q) : '0;
  assign rsp_read_data           = rsp_rdata_q;
  assign rsp_no_response         = rsp_nr_q;
  assign rsp_timeout             = rsp_to_q;
  assign rsp_total_written       = rsp_tw_q;
  assign rsp_total_read          = rsp_tr_q;
  assign arb_busy                = (state_q != StIdle);
  assign m_i2c_address           = m_addr_q;
  assign m_write_data            = m_wdata_q;
  assign m_write_transfer_length = m_wlen_q;
  assign m_read_transfer_length  = m_rlen_q;
  assign m_start                 = m_start_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed, table-driven bench for i2c_master_arbiter with a behavioural i2c_master model.
module tb_i2c_master_arbiter;
  localparam int NR = 4;
  localparam int TO = 100;
  localparam int ModeNormal = 0;
  localparam int ModeNack   = 1;
  localparam int ModeNoBusy = 2;
  localparam int ModeHang   = 3;
`ifdef I2C_ARB_RETRY_EN
  localparam int NackStarts = 4;
`else
  localparam int NackStarts = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [27:0] req_address;
  logic [63:0] req_write_data;
  logic [7:0]  req_write_length;
  logic [7:0]  req_read_length;
  logic [3:0]  req_ack;
  logic [3:0]  rsp_done;
  logic [15:0] rsp_read_data;
  logic        rsp_no_response;
  logic        rsp_timeout;
  logic [1:0]  rsp_total_written;
  logic [1:0]  rsp_total_read;
  logic        arb_busy;
  logic [6:0]  m_i2c_address;
  logic [15:0] m_write_data;
  logic [1:0]  m_write_transfer_length;
  logic [1:0]  m_read_transfer_length;
  logic        m_start;
  logic [15:0] m_read_data     = '0;
  logic        m_busy          = 1'b0;
  logic        m_complete      = 1'b0;
  logic        m_no_response   = 1'b0;
  logic [1:0]  m_total_written = '0;
  logic [1:0]  m_total_read    = '0;

  i2c_master_arbiter #(
    .NUM_REQ            (NR),
    .MAX_TRANSFER_LENGTH(2),
    .TIMEOUT_CYCLES     (TO),
    .MAX_RETRIES        (3)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .req_valid              (req_valid),
    .req_address            (req_address),
    .req_write_data         (req_write_data),
    .req_write_length       (req_write_length),
    .req_read_length        (req_read_length),
    .req_ack                (req_ack),
    .rsp_done               (rsp_done),
    .rsp_read_data          (rsp_read_data),
    .rsp_no_response        (rsp_no_response),
    .rsp_timeout            (rsp_timeout),
    .rsp_total_written      (rsp_total_written),
    .rsp_total_read         (rsp_total_read),
    .arb_busy               (arb_busy),
    .m_i2c_address          (m_i2c_address),
    .m_write_data           (m_write_data),
    .m_write_transfer_length(m_write_transfer_length),
    .m_read_transfer_length (m_read_transfer_length),
    .m_start                (m_start),
    .m_read_data            (m_read_data),
    .m_busy                 (m_busy),
    .m_complete             (m_complete),
    .m_no_response          (m_no_response),
    .m_total_written        (m_total_written),
    .m_total_read           (m_total_read)
  );

  always #5 clk = ~clk;

  logic [58:0] all_outs;
  assign all_outs = {req_ack, rsp_done, rsp_read_data, rsp_no_response, rsp_timeout,
                     rsp_total_written, rsp_total_read, arb_busy, m_i2c_address, m_write_data,
                     m_write_transfer_length, m_read_transfer_length, m_start};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Master model: reacts 3 time units after each rising edge.
  int          model_mode  = ModeNormal;
  logic [15:0] model_rdata = '0;
  int          model_cnt   = 0;

  task automatic model_finish();
    m_busy          = 1'b0;
    m_complete      = 1'b1;
    m_no_response   = (model_mode == ModeNack);
    m_read_data     = (model_mode == ModeNack) ? 16'h0 : model_rdata;
    m_total_written = (model_mode == ModeNack) ? 2'd0 : m_write_transfer_length;
    m_total_read    = (model_mode == ModeNack) ? 2'd0 : m_read_transfer_length;
  endtask

  always @(posedge clk) begin
    #3;
    if (rst) begin
      m_busy     = 1'b0;
      m_complete = 1'b0;
      model_cnt  = 0;
    end else begin
      m_complete = 1'b0;
      if (m_start) begin
        if (model_mode == ModeNoBusy) begin
          model_finish();
        end else begin
          m_busy    = 1'b1;
          model_cnt = (model_mode == ModeHang) ? 0 : 3;
        end
      end else if (model_cnt > 0) begin
        model_cnt = model_cnt - 1;
        if (model_cnt == 0) model_finish();
      end
    end
  end

  // Event log, sampled mid-cycle.
  int ack_cyc[$];
  int ack_vec[$];
  int start_cyc[$];
  int done_cyc[$];
  int done_vec[$];
  int comp_cyc[$];
  always @(negedge clk) begin
    if (req_ack != 0) begin
      ack_cyc.push_back(cyc);
      ack_vec.push_back(int'(req_ack));
    end
    if (m_start) start_cyc.push_back(cyc);
    if (rsp_done != 0) begin
      done_cyc.push_back(cyc);
      done_vec.push_back(int'(rsp_done));
    end
    if (m_complete) comp_cyc.push_back(cyc);
  end

  function automatic int qget(input int q[$], input int idx);
    if (idx >= 0 && idx < q.size()) return q[idx];
    return -1;
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic set_desc(input int r, input logic [6:0] a, input logic [15:0] d,
                          input logic [1:0] wl, input logic [1:0] rl);
    req_address[7*r +: 7]      = a;
    req_write_data[16*r +: 16] = d;
    req_write_length[2*r +: 2] = wl;
    req_read_length[2*r +: 2]  = rl;
  endtask

  typedef struct {
    int          req;
    logic [6:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  wlen;
    logic [1:0]  rlen;
    int          mode;
    logic [15:0] mrdata;
    logic [1:0]  exp_mwl;
    logic [1:0]  exp_mrl;
    logic [3:0]  exp_done;
    logic [15:0] exp_rd;
    logic        exp_nr;
    logic        exp_to;
    logic [1:0]  exp_tw;
    logic [1:0]  exp_tr;
    int          exp_starts;
  } vec_t;

  vec_t vecs[7];
  vec_t v;
  int   c, n_ack, n_st, n_dn, got, k;
  string p;

  initial begin
    vecs[0] = '{1, 7'h2D, 16'hF005, 2'd2, 2'd2, ModeNormal, 16'hA55A,
                2'd2, 2'd2, 4'b0010, 16'hA55A, 1'b0, 1'b0, 2'd2, 2'd2, 1};
    vecs[1] = '{2, 7'h50, 16'h1234, 2'd3, 2'd1, ModeNormal, 16'h00BE,
                2'd2, 2'd1, 4'b0100, 16'h00BE, 1'b0, 1'b0, 2'd2, 2'd1, 1};
    vecs[2] = '{0, 7'h11, 16'hFFFF, 2'd0, 2'd0, ModeNormal, 16'h1111,
                2'd0, 2'd0, 4'b0001, 16'h0000, 1'b0, 1'b0, 2'd0, 2'd0, 0};
    vecs[3] = '{3, 7'h7F, 16'h00AA, 2'd1, 2'd0, ModeNack, 16'h9999,
                2'd1, 2'd0, 4'b1000, 16'h0000, 1'b1, 1'b0, 2'd0, 2'd0, NackStarts};
    vecs[4] = '{2, 7'h22, 16'h0F0F, 2'd1, 2'd2, ModeNoBusy, 16'h5A5A,
                2'd1, 2'd2, 4'b0100, 16'h5A5A, 1'b0, 1'b0, 2'd1, 2'd2, 1};
    vecs[5] = '{0, 7'h33, 16'h0000, 2'd2, 2'd2, ModeHang, 16'h7777,
                2'd2, 2'd2, 4'b0001, 16'h0000, 1'b1, 1'b1, 2'd0, 2'd0, 1};
    vecs[6] = '{1, 7'h44, 16'hBEEF, 2'd2, 2'd1, ModeNormal, 16'hC3C3,
                2'd2, 2'd1, 4'b0010, 16'hC3C3, 1'b0, 1'b0, 2'd2, 2'd1, 1};

    rst              = 1'b1;
    req_valid        = '0;
    req_address      = '0;
    req_write_data   = '0;
    req_write_length = '0;
    req_read_length  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'(all_outs), 64'd0);
    rst = 1'b0;
    tick();
    check("idle_not_busy", 64'(arb_busy), 64'd0);

    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      p = $sformatf("v%0d", i);
      n_ack = ack_cyc.size();
      n_st  = start_cyc.size();
      n_dn  = done_cyc.size();
      model_mode  = v.mode;
      model_rdata = v.mrdata;
      set_desc(v.req, v.addr, v.wdata, v.wlen, v.rlen);
      c = cyc;
      req_valid = 4'b0001 << v.req;
      tick();
      req_valid = '0;
      got = 0;
      for (int w = 0; w < 400 && got == 0; w++) begin
        tick();
        if (done_cyc.size() > n_dn) got = 1;
      end
      check({p, "_done_seen"}, 64'(got), 64'd1);
      check({p, "_ack_vec"}, 64'(qget(ack_vec, n_ack)), 64'(4'b0001 << v.req));
      check({p, "_ack_cycle"}, 64'(qget(ack_cyc, n_ack)), 64'(c + 1));
      check({p, "_m_addr"}, 64'(m_i2c_address), 64'(v.addr));
      check({p, "_m_wdata"}, 64'(m_write_data), 64'(v.wdata));
      check({p, "_m_wlen"}, 64'(m_write_transfer_length), 64'(v.exp_mwl));
      check({p, "_m_rlen"}, 64'(m_read_transfer_length), 64'(v.exp_mrl));
      check({p, "_start_count"}, 64'(start_cyc.size() - n_st), 64'(v.exp_starts));
      if (v.exp_starts > 0) begin
        check({p, "_start_cycle"}, 64'(qget(start_cyc, n_st)), 64'(c + 2));
      end
      check({p, "_done_vec"}, 64'(qget(done_vec, n_dn)), 64'(v.exp_done));
      if (v.exp_starts == 0) begin
        check({p, "_zero_len_done_cycle"}, 64'(qget(done_cyc, n_dn)), 64'(c + 1));
      end else if (v.mode == ModeHang) begin
        check({p, "_timeout_latency"},
              64'(qget(done_cyc, n_dn) - qget(start_cyc, n_st)), 64'(TO));
      end else begin
        check({p, "_done_latency"}, 64'(qget(done_cyc, n_dn)),
              64'(qget(comp_cyc, comp_cyc.size() - 1) + 1));
      end
      check({p, "_rsp_rdata"}, 64'(rsp_read_data), 64'(v.exp_rd));
      check({p, "_rsp_nack"}, 64'(rsp_no_response), 64'(v.exp_nr));
      check({p, "_rsp_timeout"}, 64'(rsp_timeout), 64'(v.exp_to));
      check({p, "_rsp_written"}, 64'(rsp_total_written), 64'(v.exp_tw));
      check({p, "_rsp_read"}, 64'(rsp_total_read), 64'(v.exp_tr));
    end

    // Round-robin from reset with all requesters held high.
    apply_reset();
    model_mode  = ModeNormal;
    model_rdata = 16'h0101;
    for (int r = 0; r < NR; r++) set_desc(r, 7'(7'h10 + r), 16'(16'h0100 * r), 2'd1, 2'd1);
    n_st = start_cyc.size();
    n_dn = done_cyc.size();
    req_valid = 4'b1111;
    k = 0;
    for (int w = 0; w < 600 && k < 8; w++) begin
      tick();
      if (rsp_done != 0) begin
        check($sformatf("rr_done_%0d", k), 64'(rsp_done), 64'(4'b0001 << (k % NR)));
        k++;
        if (k == 8) req_valid = '0;
      end
    end
    check("rr_count", 64'(k), 64'd8);
    check("back_to_back_gap", 64'(qget(start_cyc, n_st + 1) - qget(done_cyc, n_dn)), 64'd3);

    // Asynchronous reset while the master is busy.
    tick();
    model_mode = ModeHang;
    set_desc(3, 7'h5C, 16'hCAFE, 2'd2, 2'd2);
    n_st = start_cyc.size();
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    got = 0;
    for (int w = 0; w < 20 && got == 0; w++) begin
      tick();
      if (start_cyc.size() > n_st) got = 1;
    end
    check("midreset_start_seen", 64'(got), 64'd1);
    repeat (3) tick();
    check("midreset_busy_before", 64'(arb_busy), 64'd1);
    n_dn = done_cyc.size();
    #3;
    rst = 1'b1;
    #1;
    check("midreset_outputs_zero", 64'(all_outs), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) tick();
    check("midreset_no_done", 64'(done_cyc.size() - n_dn), 64'd0);
    check("midreset_idle", 64'(arb_busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
